bn_act_stream: RTL

- Streaming post-convolution stage for the MobileNetV3-small datapath.
- Consumes the convolution output as a channel-interleaved element stream: for each pixel in raster order, channels 0..CHANNELS-1 in turn.
- Applies folded batch-norm (per-channel scale and bias), saturates, then applies the selected activation (identity, ReLU or hard-swish).
- Fully pipelined with valid/ready backpressure; feeds the next conv or depthwise stage.

---
 rtl/mnv3_pkg.sv | 30 +++
 rtl/bn_act_stream_if.sv | 28 ++
 rtl/hswish_unit.sv | 33 +++
 rtl/bn_act_stream.sv | 131 +++++++++++++
 4 files changed

// File: rtl/mnv3_pkg.sv
// Shared definitions for the MobileNetV3-small datapath.
//   act_e      : activation selector encoding
//   INV6       : Q16 reciprocal of 6 used by hard-swish
//   INV6_SHIFT : fractional bits of INV6
//   sat_dw     : saturate a signed 64-bit value to a signed dw-bit range
package mnv3_pkg;

  typedef enum logic [1:0] {
    ACT_NONE   = 2'd0,
    ACT_RELU   = 2'd1,
    ACT_HSWISH = 2'd2
  } act_e;

  localparam int INV6       = 10923;
  localparam int INV6_SHIFT = 16;

  // The result is still 64 bits wide; callers size-cast it to dw bits,
  // which is lossless because the value already lies in the dw range.
  function automatic logic signed [63:0] sat_dw(input logic signed [63:0] x,
                                                input int                 dw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (x > hi)      sat_dw = hi;
    else if (x < lo) sat_dw = lo;
    else             sat_dw = x;
  endfunction

endpackage

// File: rtl/bn_act_stream_if.sv
// Stream bundle between bn_act_stream and its neighbours.
//   in_data/in_valid/in_ready     : upstream element handshake
//   out_data/out_valid/out_ready  : downstream element handshake
//   out_last                      : final element of a frame
//   frame_done                    : pulse on acceptance of the out_last element
// slave = the processing block, master = the environment around it.
interface bn_act_stream_if #(
  parameter int DATA_WIDTH = 8
);
  logic signed [DATA_WIDTH-1:0] in_data;
  logic                         in_valid;
  logic                         in_ready;
  logic signed [DATA_WIDTH-1:0] out_data;
  logic                         out_valid;
  logic                         out_ready;
  logic                         out_last;
  logic                         frame_done;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last, frame_done
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last, frame_done
  );
endinterface

// File: rtl/hswish_unit.sv
// Combinational hard-swish on a signed Q(FRAC_BITS) value.
//   y   : input value
//   out : sat(y * clamp(y + 3, 0, 6) / 6), floored toward -inf
// Kept standalone so the squeeze-excite path can share it.
module hswish_unit
  import mnv3_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FRAC_BITS  = 4
) (
  input  logic signed [DATA_WIDTH-1:0] y,
  output logic signed [DATA_WIDTH-1:0] out
);

  localparam logic signed [63:0] THREE = 64'sd3 <<< FRAC_BITS;
  localparam logic signed [63:0] SIX   = 64'sd6 <<< FRAC_BITS;

  logic signed [63:0] y_ext;
  logic signed [63:0] t;
  logic signed [63:0] prod;

  always_comb begin
    y_ext = 64'(y);
    t     = y_ext + THREE;
    if (t < 64'sd0)  t = 64'sd0;
    else if (t > SIX) t = SIX;
    // y*t carries 2*FRAC_BITS fraction, INV6 adds INV6_SHIFT more; drop
    // FRAC_BITS+INV6_SHIFT to land back on Q(FRAC_BITS).
    prod = (y_ext * t * 64'(INV6)) >>> (FRAC_BITS + INV6_SHIFT);
    out  = DATA_WIDTH'(sat_dw(prod, DATA_WIDTH));
  end

endmodule

// File: rtl/bn_act_stream.sv
// Folded batch-norm + activation stage on a channel-interleaved stream.
//   clk, rst      : clock, asynchronous active-high reset
//   scale, bias   : per-channel Q(FRAC_BITS) BN coefficients, static per frame
//   bus (slave)   : in/out valid-ready stream, out_last, frame_done
// Three-stage pipe: S1 multiply, S2 shift+bias+saturate, S3 activation.
// A single global stall (output valid but not taken) freezes every stage.
module bn_act_stream
  import mnv3_pkg::*;
#(
  parameter int CHANNELS   = 16,
  parameter int HEIGHT     = 112,
  parameter int WIDTH      = 112,
  parameter int DATA_WIDTH = 8,
  parameter int FRAC_BITS  = 4,
  parameter int ACT        = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [DATA_WIDTH-1:0] scale [0:CHANNELS-1],
  input  logic signed [DATA_WIDTH-1:0] bias  [0:CHANNELS-1],
  bn_act_stream_if.slave               bus
);

  localparam int   ELEMS   = HEIGHT * WIDTH * CHANNELS;
  localparam int   CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int   EL_W    = (ELEMS > 1) ? $clog2(ELEMS) : 1;
  localparam int   PW      = 2 * DATA_WIDTH;
  localparam act_e ACT_SEL = act_e'(ACT);

  logic                         stall;
  logic                         in_fire;
  logic                         in_last;

  logic [CH_W-1:0]              ch_cnt;
  logic [EL_W-1:0]              elem_cnt;

  logic                         s1_valid;
  logic signed [PW-1:0]         s1_prod;
  logic [CH_W-1:0]              s1_ch;
  logic                         s1_last;

  logic                         s2_valid;
  logic signed [DATA_WIDTH-1:0] s2_y;
  logic                         s2_last;

  logic                         s3_valid;
  logic signed [DATA_WIDTH-1:0] s3_data;
  logic                         s3_last;

  logic signed [63:0]           s2_sum;
  logic signed [DATA_WIDTH-1:0] s2_y_d;
  logic signed [DATA_WIDTH-1:0] hs_out;
  logic signed [DATA_WIDTH-1:0] act_y;

  assign stall   = s3_valid && !bus.out_ready;
  assign in_fire = bus.in_valid && !stall;
  assign in_last = (elem_cnt == EL_W'(ELEMS - 1));

  assign bus.in_ready   = !stall;
  assign bus.out_valid  = s3_valid;
  assign bus.out_data   = s3_data;
  assign bus.out_last   = s3_last;
  assign bus.frame_done = s3_valid && bus.out_ready && s3_last;

  always_comb begin
    s2_sum = 64'(s1_prod >>> FRAC_BITS) + 64'(bias[s1_ch]);
    s2_y_d = DATA_WIDTH'(sat_dw(s2_sum, DATA_WIDTH));
  end

  hswish_unit #(
    .DATA_WIDTH (DATA_WIDTH),
    .FRAC_BITS  (FRAC_BITS)
  ) u_hswish (
    .y   (s2_y),
    .out (hs_out)
  );

  always_comb begin
    act_y = s2_y;
    case (ACT_SEL)
      ACT_RELU:   act_y = s2_y[DATA_WIDTH-1] ? '0 : s2_y;
      ACT_HSWISH: act_y = hs_out;
      default:    act_y = s2_y;
    endcase
  end

  // Counters only move on accepted inputs, so bubbles leave frame position intact.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_cnt   <= '0;
      elem_cnt <= '0;
    end else if (in_fire) begin
      ch_cnt   <= (ch_cnt == CH_W'(CHANNELS - 1)) ? '0 : ch_cnt + 1'b1;
      elem_cnt <= in_last ? '0 : elem_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_prod  <= '0;
      s1_ch    <= '0;
      s1_last  <= 1'b0;
      s2_valid <= 1'b0;
      s2_y     <= '0;
      s2_last  <= 1'b0;
      s3_valid <= 1'b0;
      s3_data  <= '0;
      s3_last  <= 1'b0;
    end else if (!stall) begin
      s1_valid <= bus.in_valid;
      if (in_fire) begin
        s1_prod <= PW'(bus.in_data) * PW'(scale[ch_cnt]);
        s1_ch   <= ch_cnt;
        s1_last <= in_last;
      end

      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_y    <= s2_y_d;
        s2_last <= s1_last;
      end

      s3_valid <= s2_valid;
      // A bubble clears last so a stale flag can never pair with a later element.
      s3_last  <= s2_valid && s2_last;
      if (s2_valid) s3_data <= act_y;
    end
  end

endmodule
